// File: rtl/sram_pkg.sv
// sram_pkg: shared constants and helpers for the SRAM row-slice behavioural model.
//   VDD_V / VSS_V       : supply rails (volts)
//   SA_THRESH_V         : differential needed for a decision (volts)
//   DISCHARGE_STEP_V    : bitline droop per read cycle (volts)
//   KMAX                : discharge counter saturation, ceil(VDD_V / DISCHARGE_STEP_V)
//   diff_to_bit()       : threshold-with-hold decision shared by cell write and sense amp
package sram_pkg;

  localparam real VDD_V            = 1.0;
  localparam real VSS_V            = 0.0;
  localparam real SA_THRESH_V      = 0.1;
  localparam real DISCHARGE_STEP_V = 0.05;

  // The small epsilon keeps binary rounding of the quotient from pushing ceil() up by one.
  localparam int  KMAX = int'($ceil(VDD_V / DISCHARGE_STEP_V - 1.0e-9));
  localparam int  K_W  = $clog2(KMAX + 1);

  // Resolve a differential pair to a bit; inside the dead band the previous value holds.
  function automatic logic diff_to_bit(real a, real b, logic prev);
    if ((a - b) > SA_THRESH_V) return 1'b1;
    if ((b - a) > SA_THRESH_V) return 1'b0;
    return prev;
  endfunction

endpackage

// File: rtl/sram_cell_rw_path_if.sv
// sram_cell_rw_path_if: access bus of one SRAM row slice.
//   data_in  : write data, one bit per column
//   wr       : path select, 0 = write driver, 1 = read/precharge
//   row_wr   : wordline, 1 = row access active
//   obl_col  : cell-side true bitline voltage per column
//   oblb_col : cell-side complement bitline voltage per column
//   preout   : registered sense-amp decision per column
// master = row decoder / data I/O side, slave = the row slice.
interface sram_cell_rw_path_if #(
  parameter int COLS = 1
);

  logic [COLS-1:0] data_in;
  logic            wr;
  logic            row_wr;
  real             obl_col  [COLS];
  real             oblb_col [COLS];
  logic [COLS-1:0] preout;

  modport master (
    output data_in, wr, row_wr,
    input  obl_col, oblb_col, preout
  );

  modport slave (
    input  data_in, wr, row_wr,
    output obl_col, oblb_col, preout
  );

endinterface

// File: rtl/sram_sense_col.sv
// sram_sense_col: clocked sense amplifier for one column.
//   clk, rst_n : clock, synchronous active-low reset
//   obl, oblb  : registered bitline pair from the cell
//   preout     : decision; updates only when the pair differs by more than SA_THRESH_V
module sram_sense_col
  import sram_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  real  obl,
  input  real  oblb,
  output logic preout
);

  always_ff @(posedge clk) begin
    if (!rst_n) preout <= 1'b0;
    else        preout <= diff_to_bit(obl, oblb, preout);
  end

endmodule

// File: rtl/sram_cell_rw_path.sv
// sram_cell_rw_path: behavioural row slice -- write driver, bitline mux, bitcells with
// real-valued differential bitlines, and a per-column clocked sense amp.
//   clk    : clock, all state changes on the rising edge
//   rst_n  : synchronous active-low reset (clears cells, counter, sense amps; precharges lines)
//   bus    : sram_cell_rw_path_if.slave (data_in, wr, row_wr in; obl_col, oblb_col, preout out)
// Configuration macro SRAM_READ_RAMP_EN:
//   defined     -> bitline discharges DISCHARGE_STEP_V per read cycle (sense valid on 4th edge)
//   not defined -> full swing on the first read edge (sense valid on 2nd edge)
module sram_cell_rw_path
  import sram_pkg::*;
#(
  parameter int COLS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sram_cell_rw_path_if.slave   bus
);

  real             bl_col  [COLS];
  real             blb_col [COLS];
  real             obl_q   [COLS];
  real             oblb_q  [COLS];
  logic [COLS-1:0] q;
  logic [K_W-1:0]  k;
  logic [K_W-1:0]  k_nxt;
  real             rd_low;
  logic [COLS-1:0] preout_w;
  logic            rd_en;
  logic            wr_en;

  assign rd_en = bus.row_wr &  bus.wr;
  assign wr_en = bus.row_wr & ~bus.wr;

  // Write driver and mux: the write path drives full rails, the read path precharges both lines.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    for (int i = 0; i < COLS; i++) begin
      bl_col[i]  = VDD_V;
      blb_col[i] = VDD_V;
      if (!bus.wr) begin
        bl_col[i]  = bus.data_in[i] ? VDD_V : VSS_V;
        blb_col[i] = bus.data_in[i] ? VSS_V : VDD_V;
      end
    end
  end

  assign k_nxt = (k == K_W'(KMAX)) ? k : k + 1'b1;

  // Level of the discharging line after this edge's read.
  always_comb begin
`ifdef SRAM_READ_RAMP_EN
    rd_low = VDD_V - real'(k_nxt) * DISCHARGE_STEP_V;
    if (rd_low < VSS_V) rd_low = VSS_V;
`else
    rd_low = VSS_V;
`endif
  end

  // Cell state, discharge counter and registered bitlines. Any non-read edge (idle or write)
  // clears the counter and returns the lines to precharge.
  // NOTE: state uses non-blocking assignments so every register samples pre-edge values;
  // the cell array is tiny, so it is reset along with the rest of the state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
      k <= '0;
      for (int i = 0; i < COLS; i++) begin
        obl_q[i]  <= VDD_V;
        oblb_q[i] <= VDD_V;
      end
    end else begin
      if (wr_en) begin
        for (int i = 0; i < COLS; i++) q[i] <= diff_to_bit(bl_col[i], blb_col[i], q[i]);
      end
      k <= rd_en ? k_nxt : '0;
      for (int i = 0; i < COLS; i++) begin
        if (rd_en) begin
          obl_q[i]  <= q[i] ? VDD_V  : rd_low;
          oblb_q[i] <= q[i] ? rd_low : VDD_V;
        end else begin
          obl_q[i]  <= VDD_V;
          oblb_q[i] <= VDD_V;
        end
      end
    end
  end

  // The sense amp sees the pre-edge bitlines, so a write edge still resolves the stale read.
  for (genvar g = 0; g < COLS; g++) begin : g_col
    sram_sense_col u_sense (
      .clk    (clk),
      .rst_n  (rst_n),
      .obl    (obl_q[g]),
      .oblb   (oblb_q[g]),
      .preout (preout_w[g])
    );
    assign bus.obl_col[g]  = obl_q[g];
    assign bus.oblb_col[g] = oblb_q[g];
  end

  assign bus.preout = preout_w;

endmodule

// File: tb/tb_sram_cell_rw_path.sv
// tb_sram_cell_rw_path: scoreboard bench for a 4-column row slice. A reference model predicts
// lines and sense outputs for every edge; predictions are queued when stimulus is driven and
// compared after the edge. Works with or without SRAM_READ_RAMP_EN.
module tb_sram_cell_rw_path;

  localparam int COLS = 4;
`ifdef SRAM_READ_RAMP_EN
  localparam bit RAMP = 1'b1;
`else
  localparam bit RAMP = 1'b0;
`endif

  typedef struct {
    string tag;
    real   val;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];

  // Reference model state (pre-edge).
  logic [COLS-1:0] m_q   = '0;
  int              m_k   = 0;
  real             m_obl  [COLS];
  real             m_oblb [COLS];
  logic [COLS-1:0] m_pre = '0;

  sram_cell_rw_path_if #(.COLS(COLS)) bus_if ();

  sram_cell_rw_path #(.COLS(COLS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input real obs, input real exp);
    n_checks++;
    if ((obs - exp) > 1.0e-6 || (exp - obs) > 1.0e-6) begin
      n_errors++;
      $display("FAIL %s: got %f expected %f", tag, obs, exp);
    end
  endtask

  // Predict the outcome of the coming edge and queue it.
  task automatic model_push(input logic rst, input logic w, input logic row,
                            input logic [COLS-1:0] d, input string tag);
    real lvl;
    if (!rst) begin
      m_q = '0;
      m_k = 0;
      m_pre = '0;
      for (int i = 0; i < COLS; i++) begin
        m_obl[i]  = 1.0;
        m_oblb[i] = 1.0;
      end
    end else begin
      for (int i = 0; i < COLS; i++) begin
        if      (m_obl[i] - m_oblb[i] > 0.1) m_pre[i] = 1'b1;
        else if (m_oblb[i] - m_obl[i] > 0.1) m_pre[i] = 1'b0;
      end
      if (row && w) begin
        m_k = (m_k < 20) ? m_k + 1 : 20;
        lvl = RAMP ? (1.0 - m_k * 0.05) : 0.0;
        if (lvl < 0.0) lvl = 0.0;
        for (int i = 0; i < COLS; i++) begin
          m_obl[i]  = m_q[i] ? 1.0 : lvl;
          m_oblb[i] = m_q[i] ? lvl : 1.0;
        end
      end else begin
        // Full-rail driver always clears the threshold, so a write just stores the data.
        if (row) m_q = d;
        m_k = 0;
        for (int i = 0; i < COLS; i++) begin
          m_obl[i]  = 1.0;
          m_oblb[i] = 1.0;
        end
      end
    end
    for (int i = 0; i < COLS; i++) sb.push_back('{$sformatf("%s obl%0d", tag, i), m_obl[i]});
    for (int i = 0; i < COLS; i++) sb.push_back('{$sformatf("%s oblb%0d", tag, i), m_oblb[i]});
    sb.push_back('{$sformatf("%s preout", tag), real'(m_pre)});
  endtask

  // Drive one cycle, then compare the queued prediction against the DUT after the edge.
  task automatic step(input logic rst, input logic w, input logic row,
                      input logic [COLS-1:0] d, input string tag);
    exp_t e;
    rst_n          = rst;
    bus_if.wr      = w;
    bus_if.row_wr  = row;
    bus_if.data_in = d;
    model_push(rst, w, row, d, tag);
    @(posedge clk);
    #1;
    for (int i = 0; i < COLS; i++) begin
      e = sb.pop_front();
      check(e.tag, bus_if.obl_col[i], e.val);
    end
    for (int i = 0; i < COLS; i++) begin
      e = sb.pop_front();
      check(e.tag, bus_if.oblb_col[i], e.val);
    end
    e = sb.pop_front();
    check(e.tag, real'(bus_if.preout), e.val);
  endtask

  task automatic write_cycle(input logic [COLS-1:0] d, input string tag);
    step(1'b1, 1'b0, 1'b1, d, tag);
  endtask

  task automatic read_cycles(input int n, input string tag);
    for (int c = 0; c < n; c++) step(1'b1, 1'b1, 1'b1, '0, $sformatf("%s rd%0d", tag, c));
  endtask

  task automatic idle_cycle(input string tag);
    step(1'b1, 1'b1, 1'b0, '0, tag);
  endtask

  initial begin
    rst_n          = 1'b0;
    bus_if.wr      = 1'b1;
    bus_if.row_wr  = 1'b0;
    bus_if.data_in = '0;
    @(negedge clk);

    // Reset, with an access pending to show reset wins.
    step(1'b0, 1'b0, 1'b1, 4'b1111, "reset0");
    step(1'b0, 1'b1, 1'b1, 4'b0000, "reset1");
    check("reset preout", real'(bus_if.preout), 0.0);
    check("reset obl0", bus_if.obl_col[0], 1.0);
    idle_cycle("idle0");

    // Write 1 to column 0, then read with ramp.
    write_cycle(4'b0001, "w0001");
    read_cycles(5, "r0001");
    check("read 0001 preout", real'(bus_if.preout), 1.0);
    check("read 0001 obl0", bus_if.obl_col[0], 1.0);
    idle_cycle("idle1");

    // Write 0 everywhere, read: preout falls to 0.
    write_cycle(4'b0000, "w0000");
    read_cycles(5, "r0000");
    check("read 0000 preout", real'(bus_if.preout), 0.0);
    idle_cycle("idle2");

    // All ones, then a short read of zeros: with ramp the differential stays in the dead band.
    write_cycle(4'b1111, "w1111");
    read_cycles(5, "r1111");
    check("read 1111 preout", real'(bus_if.preout), 15.0);
    write_cycle(4'b0000, "w0000b");
    read_cycles(2, "short");
    idle_cycle("idle3");
    idle_cycle("idle4");

    // Alternating pattern across the slice.
    write_cycle(4'b1010, "w1010");
    read_cycles(5, "r1010");
    check("read 1010 preout", real'(bus_if.preout), 10.0);

    // wr toggled with the wordline held: write edge clears k, sense sees stale lines.
    write_cycle(4'b0101, "w0101");
    read_cycles(1, "r0101");
    write_cycle(4'b1100, "w1100");
    read_cycles(5, "r1100");
    check("read 1100 preout", real'(bus_if.preout), 12.0);

    // Long read to reach counter saturation.
    read_cycles(25, "rsat");
    check("sat oblb3", bus_if.oblb_col[3], 0.0);
    check("sat obl0", bus_if.obl_col[0], 0.0);

    // Reset in the middle of a read.
    write_cycle(4'b1010, "w1010b");
    read_cycles(3, "rmid");
    step(1'b0, 1'b1, 1'b1, '0, "rst_mid");
    check("mid reset preout", real'(bus_if.preout), 0.0);
    check("mid reset oblb1", bus_if.oblb_col[1], 1.0);
    read_cycles(5, "rpost");
    check("post reset preout", real'(bus_if.preout), 0.0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
